// File: rtl/fpu_sgnj_pipe.sv
// -----------------------------------------------------------------------------
// fpu_sgnj_pipe
//
// Two-stage, valid/ready handshaked sign-injection unit for single-precision
// operands. Executes fsgnj / fsgnjn / fsgnjx. NaN operands or an illegal
// opcode raise the exception output. NaNs are passed through bitwise, with no
// canonicalisation.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer holds its payload while valid && !ready. The payload
// (y/exception/out_tag) is held stable while out_valid && !out_ready.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rstn       asynchronous active-low reset
//   in_valid   operation offered
//   in_ready   unit accepts operation this cycle (combinational from out_ready)
//   op         00 fsgnj, 01 fsgnjn, 10 fsgnjx, 11 illegal
//   x1         magnitude source operand
//   x2         sign source operand
//   in_tag     opaque destination tag
//   out_valid  result available
//   out_ready  consumer accepts result
//   y          result
//   exception  NaN operand or illegal op
//   out_tag    tag of result
// -----------------------------------------------------------------------------
module fpu_sgnj_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic             exception,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] OP_SGNJ  = 2'b00;
    localparam logic [1:0] OP_SGNJN = 2'b01;
    localparam logic [1:0] OP_SGNJX = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    // Stage 1: raw operands plus pre-decoded exception causes.
    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_x1_q,    s1_x1_d;
    logic             s1_sgn2_q,  s1_sgn2_d;
    logic [1:0]       s1_op_q,    s1_op_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic             s1_nan_q,   s1_nan_d;
    logic             s1_ill_q,   s1_ill_d;

    // Stage 2: final result, drives the outputs directly.
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      y_q,        y_d;
    logic             exc_q,      exc_d;
    logic [TAG_W-1:0] tag_q,      tag_d;

    logic s2_adv;
    logic s1_adv;
    logic x1_nan;
    logic x2_nan;
    logic in_fire;

    always_comb begin
        // A stage may load when it is empty or its content leaves this cycle.
        s2_adv  = !s2_valid_q || out_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        in_fire = in_valid && s1_adv;

        // Quiet and signalling NaNs alike: exponent all ones, mantissa nonzero.
        x1_nan = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
        x2_nan = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);

        // Stage 1 next state. Payload only moves on an accepted input so the
        // registers do not toggle on idle cycles.
        s1_valid_d = s1_valid_q;
        s1_x1_d    = s1_x1_q;
        s1_sgn2_d  = s1_sgn2_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        s1_nan_d   = s1_nan_q;
        s1_ill_d   = s1_ill_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_x1_d   = x1;
            s1_sgn2_d = x2[31];
            s1_op_d   = op;
            s1_tag_d  = in_tag;
            s1_nan_d  = x1_nan || x2_nan;
            s1_ill_d  = (op == OP_ILL);
        end

        // Stage 2 next state. An empty S1 while S2 advances inserts a bubble;
        // the old payload is kept but no longer marked valid.
        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        exc_d      = exc_q;
        tag_d      = tag_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                unique case (s1_op_q)
                    OP_SGNJ:  y_d = {s1_sgn2_q, s1_x1_q[30:0]};
                    OP_SGNJN: y_d = {~s1_sgn2_q, s1_x1_q[30:0]};
                    OP_SGNJX: y_d = {s1_x1_q[31] ^ s1_sgn2_q, s1_x1_q[30:0]};
                    default:  y_d = s1_x1_q;
                endcase
                exc_d = s1_nan_q || s1_ill_q;
                tag_d = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_x1_q    <= '0;
            s1_sgn2_q  <= 1'b0;
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
            s1_nan_q   <= 1'b0;
            s1_ill_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            exc_q      <= 1'b0;
            tag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x1_q    <= s1_x1_d;
            s1_sgn2_q  <= s1_sgn2_d;
            s1_op_q    <= s1_op_d;
            s1_tag_q   <= s1_tag_d;
            s1_nan_q   <= s1_nan_d;
            s1_ill_q   <= s1_ill_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            exc_q      <= exc_d;
            tag_q      <= tag_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign exception = exc_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_fpu_sgnj_pipe.sv
// -----------------------------------------------------------------------------
// tb_fpu_sgnj_pipe: self-checking bench for fpu_sgnj_pipe.
// Inputs are driven just after a rising edge or on the falling edge; outputs
// are sampled on the falling edge (plus #1 where combinational settling of
// in_ready matters).
// -----------------------------------------------------------------------------
module tb_fpu_sgnj_pipe;

    localparam int TAG_W = 5;

    logic             clk;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      y;
    logic             exception;
    logic [TAG_W-1:0] out_tag;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected result entries: {exception, tag, y}
    logic [37:0] exp_q[$];

    fpu_sgnj_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x1        (x1),
        .x2        (x2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .exception (exception),
        .out_tag   (out_tag)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

    // Bitwise reference for sign injection, straight from the instruction definitions.
    function automatic logic [37:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [TAG_W-1:0] t);
        logic [31:0] r;
        logic        e;
        e = ((a[30:23] == 8'hFF) && (a[22:0] != 23'd0)) ||
            ((b[30:23] == 8'hFF) && (b[22:0] != 23'd0)) || (o == 2'b11);
        case (o)
            2'b00:   r = {b[31], a[30:0]};
            2'b01:   r = {~b[31], a[30:0]};
            2'b10:   r = {a[31] ^ b[31], a[30:0]};
            default: r = a;
        endcase
        return {e, t, r};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; op = 2'b00; x1 = '0; x2 = '0; in_tag = '0; out_ready = 1'b0;
        #7;
        tests_run++;
        if (out_valid !== 1'b0 || y !== 32'h0 || exception !== 1'b0 || out_tag !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b y=%h exc=%b tag=%0d, want 0 0 0 0",
                     out_valid, y, exception, out_tag);
        end
        @(negedge clk); #2 rstn = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  v_op[9] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b11, 2'b00, 2'b10, 2'b01};
        logic [31:0] v_x1[9] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7FC00000,
                                 32'h7F800000, 32'h12345678, 32'h3F800000, 32'h00000001, 32'h80000000};
        logic [31:0] v_x2[9] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000,
                                 32'h00000000, 32'h00000000, 32'hFF800001, 32'h80000000, 32'h7F800000};
        logic [31:0] v_y[9]  = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 32'hFFC00000,
                                 32'h7F800000, 32'h12345678, 32'hBF800000, 32'h80000001, 32'h80000000};
        logic        v_e[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int cyc;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1;
            op = v_op[i]; x1 = v_x1[i]; x2 = v_x2[i]; in_tag = TAG_W'(i + 1);
            #1;
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
            end
            @(posedge clk); #1 in_valid = 1'b0;
            cyc = 1;
            while (cyc < 10) begin
                @(negedge clk);
                if (out_valid === 1'b1) break;
                @(posedge clk);
                cyc++;
            end
            tests_run++;
            if (cyc !== 2) begin
                tests_failed++;
                $display("FAIL dir%0d_latency: got %0d cycles want 2", i, cyc);
            end
            tests_run++;
            if (y !== v_y[i] || exception !== v_e[i] || out_tag !== TAG_W'(i + 1)) begin
                tests_failed++;
                $display("FAIL dir%0d_result: got y=%h exc=%b tag=%0d want y=%h exc=%b tag=%0d",
                         i, y, exception, out_tag, v_y[i], v_e[i], i + 1);
            end
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL dir%0d_no_dup: got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; op = 2'b00; x2 = 32'h0;
        x1 = 32'h00000011; in_tag = 5'd1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_accept1: in_ready got %b want 1", in_ready);
        end
        @(posedge clk); #1 x1 = 32'h00000022; in_tag = 5'd2;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_accept2: in_ready got %b want 1", in_ready);
        end
        @(posedge clk); #1 x1 = 32'h00000033; in_tag = 5'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1 || y !== 32'h00000011) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got in_ready=%b valid=%b tag=%0d y=%h want 0 1 1 00000011",
                         k, in_ready, out_valid, out_tag, y);
            end
            if (k < 3) @(posedge clk);
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release_in_ready: got %b want 1", in_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_tag !== TAG_W'(k) || y !== 32'(k * 32'h11)) begin
                tests_failed++;
                $display("FAIL bp_drain%0d: got valid=%b tag=%0d y=%h want 1 %0d %h",
                         k, out_valid, out_tag, y, k, k * 32'h11);
            end
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_empty: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_streaming();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        logic [TAG_W-1:0] tg = '0;
        logic [37:0] e;
        exp_q.delete();
        while ((sent < 1000 || exp_q.size() != 0) && cyc < 6000) begin
            @(negedge clk);
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            out_ready = (sent >= 1000) || ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            x1 = $urandom; x2 = $urandom;
            if ($urandom_range(0, 5) == 0) x1[30:23] = 8'hFF;
            if ($urandom_range(0, 5) == 0) x2[30:23] = 8'hFF;
            if ($urandom_range(0, 3) == 0) x1[22:0] = 23'd0;
            in_tag = tg;
            #1;
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL stream_extra: got tag=%0d y=%h with nothing expected", out_tag, y);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    if ({exception, out_tag, y} !== e) begin
                        tests_failed++;
                        $display("FAIL stream_result: got exc=%b tag=%0d y=%h want exc=%b tag=%0d y=%h",
                                 exception, out_tag, y, e[37], e[36:32], e[31:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op, x1, x2, tg));
                tg++;
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (sent !== 1000 || got !== sent || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL stream_count: sent=%0d got=%0d pending=%0d want 1000 1000 0",
                     sent, got, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        int cyc;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; op = 2'b01; x1 = 32'h40000000; x2 = 32'h0; in_tag = 5'd20;
        @(posedge clk); #1 in_tag = 5'd21;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_pre_full: got valid=%b in_ready=%b want 1 0", out_valid, in_ready);
        end
        #2 rstn = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || y !== 32'h0 || out_tag !== '0 || exception !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async_clear: got valid=%b y=%h tag=%0d exc=%b want 0 0 0 0",
                     out_valid, y, out_tag, exception);
        end
        @(posedge clk); #2 rstn = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_in_ready: got %b want 1", in_ready);
        end
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        tests_run++;
        if (stale !== 0) begin
            tests_failed++;
            $display("FAIL rst_no_stale: got %0d stale cycles want 0", stale);
        end
        @(negedge clk);
        in_valid = 1'b1; op = 2'b10; x1 = 32'hC0490FDB; x2 = 32'h80000000; in_tag = 5'd9;
        @(posedge clk); #1 in_valid = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            @(posedge clk);
            cyc++;
        end
        tests_run++;
        if (cyc !== 2 || y !== 32'h40490FDB || out_tag !== 5'd9 || exception !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_after_op: got cyc=%0d y=%h tag=%0d exc=%b want 2 40490fdb 9 0",
                     cyc, y, out_tag, exception);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep();
        logic [22:0] mt[7] = '{23'h000000, 23'h000001, 23'h000002, 23'h380000,
                               23'h400000, 23'h5FFFFF, 23'h7FFFFF};
        logic [TAG_W-1:0] tg = '0;
        logic [31:0] v;
        logic [37:0] m;
        logic [37:0] e;
        logic        want_exc;
        int got  = 0;
        int sent = 0;
        int cyc  = 0;
        exp_q.delete();
        out_ready = 1'b1;
        for (int o = 0; o < 3; o++) begin
            for (int side = 0; side < 2; side++) begin
                for (int ex = 0; ex < 256; ex++) begin
                    for (int mi = 0; mi < 7; mi++) begin
                        @(negedge clk);
                        v = {1'(ex), 8'(ex), mt[mi]};
                        op = 2'(o); in_valid = 1'b1; in_tag = tg;
                        if (side == 0) begin x1 = v; x2 = 32'h80000000; end
                        else begin x1 = 32'h3F800000; x2 = v; end
                        #1;
                        if (out_valid) begin
                            tests_run++;
                            e = exp_q.pop_front();
                            got++;
                            if ({exception, out_tag, y} !== e) begin
                                tests_failed++;
                                $display("FAIL sweep_result: got exc=%b tag=%0d y=%h want exc=%b tag=%0d y=%h",
                                         exception, out_tag, y, e[37], e[36:32], e[31:0]);
                            end
                        end
                        if (in_ready) begin
                            // Exception expected purely from the swept operand's class.
                            want_exc = (ex == 255) && (mi != 0);
                            m = model(op, x1, x2, tg);
                            exp_q.push_back({want_exc, m[36:0]});
                            tg++;
                            sent++;
                        end
                    end
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        while (exp_q.size() != 0 && cyc < 20) begin
            #1;
            if (out_valid) begin
                tests_run++;
                e = exp_q.pop_front();
                got++;
                if ({exception, out_tag, y} !== e) begin
                    tests_failed++;
                    $display("FAIL sweep_drain: got exc=%b tag=%0d y=%h want exc=%b tag=%0d y=%h",
                             exception, out_tag, y, e[37], e[36:32], e[31:0]);
                end
            end
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (sent !== 3 * 2 * 256 * 7 || got !== sent) begin
            tests_failed++;
            $display("FAIL sweep_count: sent=%0d got=%0d want %0d %0d", sent, got, 3 * 2 * 256 * 7, sent);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_streaming();
        test_reset_midflight();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
